// File: rtl/sub_pipe_arbiter.sv
// Round-robin arbiter sharing one fixed-latency subtract pipeline among NUM_REQ requesters.
// Optional statistics counters are compiled in when SUB_PIPE_STATS_EN is defined.
module sub_pipe_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 3
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_x,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_y,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_diff,
  output logic                          pipe_start,
  output logic [DATA_WIDTH-1:0]         pipe_x,
  output logic [DATA_WIDTH-1:0]         pipe_y,
  input  logic [DATA_WIDTH-1:0]         pipe_diff,
  output logic                          ap_idle
`ifdef SUB_PIPE_STATS_EN
  ,
  output logic [31:0]                   stat_issue_cnt,
  output logic [31:0]                   stat_stall_cnt
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      grant_idx;
  logic                  grant_any;
  logic [PTR_W:0]        scan_sum;
  logic [PTR_W-1:0]      scan_idx;
  logic [NUM_REQ-1:0]    outstanding;
  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    capture;
  logic [DATA_WIDTH-1:0] sel_x;
  logic [DATA_WIDTH-1:0] sel_y;

  // Stage 0 coincides with pipe_start; stage LATENCY lines up with pipe_diff.
  logic [LATENCY:0]      sr_valid;
  logic [PTR_W-1:0]      sr_tag [0:LATENCY];

  // No grant while reset is held, so a request cannot slip in during reset.
  assign eligible = req_valid & ~outstanding & {NUM_REQ{~ap_rst}};

  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    req_ready = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (scan_sum >= (PTR_W+1)'(NUM_REQ)) scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
      scan_idx = scan_sum[PTR_W-1:0];
      if (!grant_any && eligible[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
    if (grant_any) req_ready[grant_idx] = 1'b1;
    sel_x = req_x[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    sel_y = req_y[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    capture = '0;
    if (sr_valid[LATENCY]) capture[sr_tag[LATENCY]] = 1'b1;
  end

  assign pipe_start = sr_valid[0];
  assign ap_idle    = ~|outstanding & ~|sr_valid;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rr_ptr      <= '0;
      outstanding <= '0;
      rsp_valid   <= '0;
      rsp_diff    <= '0;
      pipe_x      <= '0;
      pipe_y      <= '0;
      sr_valid    <= '0;
      // NOTE: the tag array is small flop storage, so it is cleared with everything else.
      for (int s = 0; s <= LATENCY; s++) sr_tag[s] <= '0;
    end else begin
      sr_valid  <= {sr_valid[LATENCY-1:0], grant_any};
      sr_tag[0] <= grant_idx;
      for (int s = 1; s <= LATENCY; s++) sr_tag[s] <= sr_tag[s-1];

      if (grant_any) begin
        rr_ptr <= (grant_idx == LAST_REQ) ? '0 : grant_idx + PTR_W'(1);
        pipe_x <= sel_x;
        pipe_y <= sel_y;
      end

      // Set and clear never collide: a requester with a pending result is not eligible.
      outstanding <= (outstanding | req_ready) & ~(rsp_valid & rsp_ready);
      rsp_valid   <= (rsp_valid & ~rsp_ready) | capture;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (capture[i]) rsp_diff[i*DATA_WIDTH +: DATA_WIDTH] <= pipe_diff;
      end
    end
  end

`ifdef SUB_PIPE_STATS_EN
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      stat_issue_cnt <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (grant_any && (stat_issue_cnt != 32'hFFFF_FFFF))
        stat_issue_cnt <= stat_issue_cnt + 32'd1;
      if (|req_valid && !grant_any && (stat_stall_cnt != 32'hFFFF_FFFF))
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sub_pipe_arbiter.sv
// Self-checking bench for sub_pipe_arbiter: transaction-level scoreboard plus a
// behavioural model of the shared subtract pipeline.
module tb_sub_pipe_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int L  = 3;

  logic            ap_clk;
  logic            ap_rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_x;
  logic [N*DW-1:0] req_y;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [N*DW-1:0] rsp_diff;
  logic            pipe_start;
  logic [DW-1:0]   pipe_x;
  logic [DW-1:0]   pipe_y;
  logic [DW-1:0]   pipe_diff;
  logic            ap_idle;
`ifdef SUB_PIPE_STATS_EN
  logic [31:0]     stat_issue_cnt;
  logic [31:0]     stat_stall_cnt;
`endif

  sub_pipe_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .LATENCY(L)) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_diff   (rsp_diff),
    .pipe_start (pipe_start),
    .pipe_x     (pipe_x),
    .pipe_y     (pipe_y),
    .pipe_diff  (pipe_diff),
    .ap_idle    (ap_idle)
`ifdef SUB_PIPE_STATS_EN
    ,
    .stat_issue_cnt (stat_issue_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Shared subtract unit: result appears L cycles after pipe_start, garbage otherwise.
  logic [DW-1:0] pd [L];
  always @(posedge ap_clk) begin
    pd[0] <= (pipe_start === 1'b1) ? pipe_x - pipe_y : DW'($urandom);
    for (int k = 1; k < L; k++) pd[k] <= pd[k-1];
  end
  assign pipe_diff = pd[L-1];

  int checks = 0;
  int errors = 0;

  // Scoreboard: round-robin pointer, outstanding set, pending results with countdown.
  typedef struct {
    int            tag;
    logic [DW-1:0] d;
    int            cnt;
  } op_t;

  op_t           m_q[$];
  int            m_ptr;
  logic [N-1:0]  m_out;
  logic [N-1:0]  m_rv;
  logic [DW-1:0] m_rd [N];
  logic          m_ps;
  logic [DW-1:0] m_px;
  logic [DW-1:0] m_py;
  int            grant_log[$];

  function automatic int model_winner();
    if (ap_rst !== 1'b0) return -1;
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (req_valid[i] === 1'b1 && !m_out[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic model_idle();
    return (m_out == '0) && (m_q.size() == 0);
  endfunction

  task automatic model_update();
    int  w;
    op_t e;
    if (ap_rst !== 1'b0) begin
      m_q.delete();
      m_ptr = 0; m_out = '0; m_rv = '0;
      m_ps = 1'b0; m_px = '0; m_py = '0;
      for (int i = 0; i < N; i++) m_rd[i] = '0;
      return;
    end
    w = model_winner();
    for (int i = 0; i < N; i++) begin
      if (m_rv[i] && rsp_ready[i] === 1'b1) begin
        m_rv[i]  = 1'b0;
        m_out[i] = 1'b0;
      end
    end
    for (int j = 0; j < m_q.size(); j++) m_q[j].cnt = m_q[j].cnt - 1;
    while (m_q.size() > 0 && m_q[0].cnt == 0) begin
      e = m_q.pop_front();
      m_rv[e.tag] = 1'b1;
      m_rd[e.tag] = e.d;
    end
    m_ps = (w >= 0);
    if (w >= 0) begin
      m_px = req_x[w*DW +: DW];
      m_py = req_y[w*DW +: DW];
      m_out[w] = 1'b1;
      m_ptr = (w + 1) % N;
      e.tag = w;
      e.d   = req_x[w*DW +: DW] - req_y[w*DW +: DW];
      e.cnt = L + 1;
      m_q.push_back(e);
    end
  endtask

  // Advance one clock: model sees pre-edge inputs; returns at the falling edge.
  task automatic tick();
    @(posedge ap_clk);
    model_update();
    @(negedge ap_clk);
  endtask

  task automatic set_op(input int i, input logic [DW-1:0] x, input logic [DW-1:0] y);
    req_x[i*DW +: DW] = x;
    req_y[i*DW +: DW] = y;
  endtask

  function automatic logic [DW-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return DW'($urandom_range(0, 15));
      default: return DW'($urandom);
    endcase
  endfunction

  task automatic apply_reset(input int cycles);
    ap_rst = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    repeat (cycles) tick();
    ap_rst = 1'b0;
  endtask

  task automatic drain(input string name);
    req_valid = '0;
    rsp_ready = '1;
    for (int c = 0; c < 40 && ap_idle !== 1'b1; c++) tick();
    rsp_ready = '0;
    #1;
    checks++;
    if (ap_idle !== 1'b1) begin
      errors++;
      $display("FAIL %s_drain_idle: ap_idle=%b required 1", name, ap_idle);
    end
  endtask

  // Drives traffic and compares every observable output against the scoreboard each cycle.
  task automatic run_traffic(input string name, input int cycles,
                             input logic [N-1:0] vmask, input bit rnd_valid,
                             input logic [N-1:0] rmask, input bit rnd_ready);
    int           w;
    logic [N-1:0] exp_ready;
    for (int c = 0; c < cycles; c++) begin
      req_valid = rnd_valid ? (N'($urandom) & vmask) : vmask;
      rsp_ready = rnd_ready ? (N'($urandom) & rmask) : rmask;
      for (int i = 0; i < N; i++) set_op(i, pick_operand(), pick_operand());
      #1;
      w = model_winner();
      exp_ready = '0;
      if (w >= 0) exp_ready[w] = 1'b1;
      checks++;
      if (req_ready !== exp_ready) begin
        errors++;
        $display("FAIL %s_req_ready c=%0d: got %b required %b", name, c, req_ready, exp_ready);
      end
      checks++;
      if (rsp_valid !== m_rv) begin
        errors++;
        $display("FAIL %s_rsp_valid c=%0d: got %b required %b", name, c, rsp_valid, m_rv);
      end
      for (int i = 0; i < N; i++) begin
        if (m_rv[i]) begin
          checks++;
          if (rsp_diff[i*DW +: DW] !== m_rd[i]) begin
            errors++;
            $display("FAIL %s_rsp_diff[%0d] c=%0d: got %h required %h",
                     name, i, c, rsp_diff[i*DW +: DW], m_rd[i]);
          end
        end
      end
      checks++;
      if (pipe_start !== m_ps) begin
        errors++;
        $display("FAIL %s_pipe_start c=%0d: got %b required %b", name, c, pipe_start, m_ps);
      end
      if (m_ps) begin
        checks++;
        if ({pipe_x, pipe_y} !== {m_px, m_py}) begin
          errors++;
          $display("FAIL %s_pipe_ops c=%0d: got %h/%h required %h/%h",
                   name, c, pipe_x, pipe_y, m_px, m_py);
        end
      end
      checks++;
      if (ap_idle !== model_idle()) begin
        errors++;
        $display("FAIL %s_ap_idle c=%0d: got %b required %b", name, c, ap_idle, model_idle());
      end
      if (w >= 0) grant_log.push_back(w);
      tick();
    end
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    req_valid = '1;
    rsp_ready = '0;
    req_x = '0;
    req_y = '0;
    @(negedge ap_clk);
    tick();
    #1;
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL reset_ready_in_reset: got %b required 0000", req_ready);
    end
    tick();
    ap_rst = 1'b0;
    req_valid = '0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, pipe_start} !== '0) begin
      errors++;
      $display("FAIL reset_flags: got req_ready=%b rsp_valid=%b pipe_start=%b required zeros",
               req_ready, rsp_valid, pipe_start);
    end
    checks++;
    if ({rsp_diff, pipe_x, pipe_y} !== '0) begin
      errors++;
      $display("FAIL reset_data: got rsp_diff=%h pipe_x=%h pipe_y=%h required zeros",
               rsp_diff, pipe_x, pipe_y);
    end
    checks++;
    if (ap_idle !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: got %b required 1", ap_idle);
    end
  endtask

  task automatic test_single_op();
    set_op(0, 32'd10, 32'd3);
    req_valid = 4'b0001;
    rsp_ready = '0;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant: got %b required 0001", req_ready);
    end
    tick();
    req_valid = '0;
    #1;
    checks++;
    if ({pipe_start, pipe_x, pipe_y, ap_idle} !== {1'b1, 32'd10, 32'd3, 1'b0}) begin
      errors++;
      $display("FAIL single_issue: got start=%b x=%0d y=%0d idle=%b required 1/10/3/0",
               pipe_start, pipe_x, pipe_y, ap_idle);
    end
    tick();
    for (int k = 2; k <= 4; k++) begin
      #1;
      checks++;
      if (rsp_valid !== '0) begin
        errors++;
        $display("FAIL single_early_rsp T+%0d: got %b required 0000", k, rsp_valid);
      end
      tick();
    end
    req_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if ({rsp_valid, rsp_diff[DW-1:0], req_ready} !== {4'b0001, 32'd7, 4'b0000}) begin
        errors++;
        $display("FAIL single_rsp_hold k=%0d: got valid=%b diff=%0d ready=%b required 0001/7/0000",
                 k, rsp_valid, rsp_diff[DW-1:0], req_ready);
      end
      tick();
    end
    rsp_ready = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL single_no_bypass: got %b required 0000", req_ready);
    end
    tick();
    rsp_ready = '0;
    #1;
    checks++;
    if ({rsp_valid, req_ready} !== {4'b0000, 4'b0001}) begin
      errors++;
      $display("FAIL single_consume: got valid=%b ready=%b required 0000/0001", rsp_valid, req_ready);
    end
    drain("single");
  endtask

  task automatic test_wrap();
    set_op(1, 32'd0, 32'd1);
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL wrap_grant: got %b required 0010", req_ready);
    end
    tick();
    req_valid = '0;
    for (int k = 1; k <= L + 1; k++) begin
      #1;
      checks++;
      if (rsp_valid[1] !== 1'b0) begin
        errors++;
        $display("FAIL wrap_early_rsp T+%0d: got %b required 0", k, rsp_valid[1]);
      end
      tick();
    end
    #1;
    checks++;
    if ({rsp_valid[1], rsp_diff[DW +: DW]} !== {1'b1, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL wrap_result: got valid=%b diff=%h required 1/ffffffff",
               rsp_valid[1], rsp_diff[DW +: DW]);
    end
    drain("wrap");
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    apply_reset(2);
    grant_log.delete();
    run_traffic("rr", 24, '1, 1'b0, '1, 1'b0);
    checks++;
    if (grant_log.size() < 5) begin
      errors++;
      $display("FAIL rr_grant_count: got %0d required at least 5", grant_log.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (grant_log[k] != exp_order[k]) begin
          errors++;
          $display("FAIL rr_order[%0d]: got %0d required %0d", k, grant_log[k], exp_order[k]);
        end
      end
    end
    drain("rr");
  endtask

  task automatic test_backpressure();
    int cnt[N];
    apply_reset(2);
    grant_log.delete();
    run_traffic("bp", 40, '1, 1'b0, 4'b1011, 1'b0);
    for (int i = 0; i < N; i++) cnt[i] = 0;
    foreach (grant_log[j]) cnt[grant_log[j]]++;
    checks++;
    if (cnt[2] != 1) begin
      errors++;
      $display("FAIL bp_blocked_grants: got %0d required 1", cnt[2]);
    end
    for (int i = 0; i < N; i++) begin
      if (i != 2) begin
        checks++;
        if (cnt[i] < 3) begin
          errors++;
          $display("FAIL bp_served[%0d]: got %0d grants required at least 3", i, cnt[i]);
        end
      end
    end
    drain("bp");
  endtask

  task automatic test_reset_mid_op();
    set_op(3, 32'd50, 32'd8);
    req_valid = 4'b1000;
    rsp_ready = '0;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL rst_mid_grant: got %b required 1000", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    #1;
    checks++;
    if (ap_idle !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_busy: ap_idle=%b required 0", ap_idle);
    end
    tick();
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    #1;
    checks++;
    if ({ap_idle, rsp_valid} !== {1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL rst_mid_after: got idle=%b rsp_valid=%b required 1/0000", ap_idle, rsp_valid);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      #1;
      checks++;
      if ({ap_idle, rsp_valid} !== {1'b1, 4'b0000}) begin
        errors++;
        $display("FAIL rst_mid_dropped k=%0d: got idle=%b rsp_valid=%b required 1/0000",
                 k, ap_idle, rsp_valid);
      end
    end
  endtask

  task automatic test_random();
    run_traffic("rand_full", 300, '1, 1'b1, '1, 1'b1);
    run_traffic("rand_part", 150, 4'b0110, 1'b1, 4'b1111, 1'b1);
    drain("rand");
  endtask

`ifdef SUB_PIPE_STATS_EN
  task automatic test_stats();
    apply_reset(2);
    req_valid = '1;
    rsp_ready = '0;
    for (int i = 0; i < N; i++) set_op(i, pick_operand(), pick_operand());
    repeat (6) tick();
    req_valid = '0;
    rsp_ready = 4'b0001;
    tick();
    req_valid = 4'b0001;
    rsp_ready = '0;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL stats_regrant: got %b required 0001", req_ready);
    end
    tick();
    req_valid = '0;
    #1;
    checks++;
    if ({stat_issue_cnt, stat_stall_cnt} !== {32'd5, 32'd2}) begin
      errors++;
      $display("FAIL stats_counts: got issue=%0d stall=%0d required 5/2",
               stat_issue_cnt, stat_stall_cnt);
    end
    drain("stats");
  endtask
`endif

  initial begin
    test_reset();
    test_single_op();
    test_wrap();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    test_random();
`ifdef SUB_PIPE_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sub_pipe_arbiter.md
Name: sub_pipe_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one fully pipelined, fixed-latency subtract unit (diff = x - y) among NUM_REQ requesters.
- Accepts operand pairs on per-requester valid/ready ports and issues at most one operation per cycle into the pipeline.
- Tracks each in-flight operation's owner tag in a LATENCY-deep shift register and routes each result to a per-requester response slot.
- Sits between kernel-side requesters and the shared subtract datapath; provides HLS-style idle status.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 32, operand/result width
- LATENCY, 3, shared pipeline latency in cycles from pipe_start to pipe_diff valid (1..8)

Ports:
- ap_clk  in  1  clock
- ap_rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester operation request
- req_ready  out  NUM_REQ  per-requester grant; handshake = valid & ready
- req_x  in  NUM_REQ*DATA_WIDTH  minuends, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_y  in  NUM_REQ*DATA_WIDTH  subtrahends, same packing as req_x
- rsp_valid  out  NUM_REQ  result pending for requester i
- rsp_ready  in  NUM_REQ  requester i consumes its result
- rsp_diff  out  NUM_REQ*DATA_WIDTH  results, same packing as req_x
- pipe_start  out  1  issue strobe to the shared pipeline
- pipe_x, pipe_y  out  DATA_WIDTH  operands to the shared pipeline
- pipe_diff  in  DATA_WIDTH  pipeline result, valid LATENCY cycles after pipe_start
- ap_idle  out  1  no operation in flight or pending

Behaviour:
- Reset (ap_rst high at a clock edge):
  - req_ready=0, rsp_valid=0, rsp_diff=0, pipe_start=0, pipe_x=0, pipe_y=0, ap_idle=1.
  - RR pointer=0; valid/tag shift register cleared; all outstanding flags cleared.
  - Reset mid-operation drops every in-flight op; pipe_diff for dropped ops is ignored.
- Eligibility: requester i is eligible when req_valid[i]=1 and outstanding[i]=0.
  - outstanding[i] is set on handshake and cleared on the rsp_valid[i] & rsp_ready[i] handshake.
  - At most one op per requester in flight or pending.
- Grant:
  - Combinational, one-hot, over eligible requesters, searching upward from the RR pointer with wrap-around.
  - req_ready[i]=1 only for the winner. No eligible requester -> req_ready all zero.
  - After a grant to i, pointer <= (i+1) mod NUM_REQ; otherwise the pointer holds.
- Issue: handshake at cycle T -> pipe_start=1 and pipe_x/pipe_y=registered operands in cycle T+1. pipe_start is a single-cycle pulse per op; back-to-back issues are allowed every cycle.
- Tracking: a valid bit plus owner tag are shifted LATENCY stages from issue. When the stage-LATENCY entry is valid, pipe_diff is captured into rsp_diff[tag] and rsp_valid[tag] is set.
- Latency: handshake at T -> rsp_valid high from cycle T+LATENCY+2 (T+5 at default). It holds until rsp_ready, and rsp_diff is stable while rsp_valid=1.
- Arithmetic: modulo 2^DATA_WIDTH, performed by the pipeline. The arbiter does not alter data.
- Simultaneous response consume and new request by the same requester: outstanding clears at the clock edge, so the new request is eligible from the next cycle (no same-cycle bypass).
- Capture into a slot whose rsp_valid=1 cannot occur, because of the one-outstanding rule.
- ap_idle = 1 when no outstanding flag is set and the shift register is empty.

Optional Feature:
- Macro: SUB_PIPE_STATS_EN.
- Defined:
  - Adds output stat_issue_cnt (32-bit): increments on every issue.
  - Adds output stat_stall_cnt (32-bit): increments each cycle where some req_valid=1 but no grant occurs.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: neither port nor counter logic exists; behaviour is otherwise identical.

Test Plan:
- Single op: req 0 x=10, y=3 at T -> pipe_start at T+1 with pipe_x=10, pipe_y=3; rsp_valid[0]=1 at T+5 with rsp_diff=7; held until rsp_ready.
- Wrap: x=0, y=1 -> rsp_diff=0xFFFFFFFF.
- All 4 requesters valid continuously from reset with immediate rsp_ready -> grants 0,1,2,3 in consecutive cycles, then 0 again once its response is consumed; results routed to the correct slots.
- Backpressure: rsp_ready[2]=0 held -> req_ready[2] never asserts for a second request; other requesters keep being served.
- Reset asserted 2 cycles after an issue -> no rsp_valid ever appears for that op; ap_idle=1 the cycle after reset.
- SUB_PIPE_STATS_EN defined: 5 issues, with 2 cycles where req_valid is high and all requesters outstanding -> stat_issue_cnt=5, stat_stall_cnt=2.
